// File: rtl/tx_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// tx_ctrl_pkg
// Shared definitions for the TX control buffer read-side sequencer.
//   - Default RAM read geometry (address / data width)
//   - Skid FIFO depth
//   - Read sequencer FSM state type
// Optional feature macro: TX_CTRL_RD_CHECKSUM_EN adds the ST_CSUM state.
// -----------------------------------------------------------------------------
package tx_ctrl_pkg;

    localparam int TX_CTRL_ADDR_WIDTH = 7;
    localparam int TX_CTRL_DATA_WIDTH = 16;
    localparam int TX_CTRL_FIFO_DEPTH = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
`ifdef TX_CTRL_RD_CHECKSUM_EN
        ,
        ST_CSUM  = 2'd3
`endif
    } tx_rd_state_t;

endpackage

// File: rtl/tx_ctrl_skid_fifo.sv
// -----------------------------------------------------------------------------
// tx_ctrl_skid_fifo
// Two-entry synchronous FIFO with a registered head. The head register drives
// the stream outputs directly, so the consumer sees flop outputs only.
// Ports:
//   clk        in   clock
//   rst_n      in   asynchronous active-low reset (clears contents and count)
//   push       in   write push_data this cycle (caller guarantees space)
//   push_data  in   entry to write
//   pop        in   remove head this cycle (ignored when empty)
//   head_data  out  current head entry
//   head_valid out  FIFO not empty
//   count      out  number of stored entries (0..2)
// -----------------------------------------------------------------------------
module tx_ctrl_skid_fifo
    import tx_ctrl_pkg::*;
#(
    parameter int WIDTH = 18
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             head_valid,
    output logic [$clog2(TX_CTRL_FIFO_DEPTH+1)-1:0] count
);

    localparam int CW = $clog2(TX_CTRL_FIFO_DEPTH + 1);

    logic [WIDTH-1:0] head_q, head_d;
    logic [WIDTH-1:0] tail_q, tail_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_pop;

    assign do_pop = pop && (count_q != '0);

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        case (count_q)
            CW'(0): begin
                if (push) begin
                    head_d  = push_data;
                    count_d = CW'(1);
                end
            end
            CW'(1): begin
                if (do_pop && push) begin
                    head_d = push_data;
                end else if (do_pop) begin
                    count_d = CW'(0);
                end else if (push) begin
                    tail_d  = push_data;
                    count_d = CW'(2);
                end
            end
            CW'(2): begin
                // Full: the tail moves up on a pop; a simultaneous push refills it.
                if (do_pop) begin
                    head_d = tail_q;
                    if (push) begin
                        tail_d = push_data;
                    end else begin
                        count_d = CW'(1);
                    end
                end
            end
            default: count_d = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    assign head_data  = head_q;
    assign head_valid = (count_q != '0);
    assign count      = count_q;

endmodule

// File: rtl/tx_ctrl_rd.sv
// -----------------------------------------------------------------------------
// tx_ctrl_rd
// Read-side sequencer for the TX control buffer RAM. On an accepted start it
// walks the RAM read port from start_addr for frame_len words (clamped to the
// RAM size, address wrapping), absorbs the one-cycle RAM read latency through a
// two-entry skid FIFO, and presents the words on a valid/ready stream.
// Ports:
//   rd_clk       in   sole clock (also the RAM read clock)
//   rd_rst_n     in   asynchronous active-low reset
//   start        in   one-cycle frame request
//   start_addr   in   first word address, sampled with start
//   frame_len    in   word count, sampled with start (0 = ignored)
//   busy         out  frame in progress (through the done cycle)
//   done         out  one-cycle pulse after the final beat is accepted
//   ram_rd_addr  out  RAM read address
//   ram_rd_data  in   RAM read data, valid the cycle after the address
//   m_data       out  stream data
//   m_valid      out  stream valid
//   m_ready      in   stream ready
//   m_last       out  final beat of the frame
// Optional feature macro: TX_CTRL_RD_CHECKSUM_EN appends a ~sum beat.
// -----------------------------------------------------------------------------
module tx_ctrl_rd
    import tx_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = TX_CTRL_ADDR_WIDTH,
    parameter int DATA_WIDTH = TX_CTRL_DATA_WIDTH,
    parameter int LEN_WIDTH  = ADDR_WIDTH + 1
) (
    input  logic                  rd_clk,
    input  logic                  rd_rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] start_addr,
    input  logic [LEN_WIDTH-1:0]  frame_len,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] ram_rd_addr,
    input  logic [DATA_WIDTH-1:0] ram_rd_data,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  m_last
);

    localparam logic [LEN_WIDTH-1:0] MAX_LEN = LEN_WIDTH'(1) << ADDR_WIDTH;
    // FIFO entry: {last, final_data_word, data}
    localparam int FW = DATA_WIDTH + 2;
    localparam int CW = $clog2(TX_CTRL_FIFO_DEPTH + 1);

    tx_rd_state_t          state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [LEN_WIDTH-1:0]  rem_q, rem_d;
    logic                  inflight_q, inflight_d;
    logic                  inflight_fin_q, inflight_fin_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
`ifdef TX_CTRL_RD_CHECKSUM_EN
    logic [DATA_WIDTH-1:0] sum_q, sum_d;
    logic                  csum_sent_q, csum_sent_d;
    logic                  csum_push;
`endif

    logic          fifo_push;
    logic [FW-1:0] fifo_push_data;
    logic          fifo_pop;
    logic [FW-1:0] fifo_head;
    logic          fifo_valid;
    logic [CW-1:0] fifo_count;
    logic [2:0]    occupancy;
    logic          issue;
    logic          head_fin;

    assign fifo_pop = fifo_valid && m_ready;
    assign head_fin = fifo_head[DATA_WIDTH];

    // Words held or on their way after this cycle; keeping this below the
    // FIFO depth is what makes overflow impossible.
    assign occupancy = {1'b0, fifo_count} + {2'b00, inflight_q} - {2'b00, fifo_pop};
    assign issue     = (state_q == ST_RUN) && (occupancy < 3'd2);

`ifdef TX_CTRL_RD_CHECKSUM_EN
    assign csum_push      = (state_q == ST_CSUM) && !csum_sent_q;
    assign fifo_push      = inflight_q || csum_push;
    // Data words never carry last here; the checksum beat closes the frame.
    assign fifo_push_data = csum_push ? {1'b1, 1'b0, ~sum_q}
                                      : {1'b0, inflight_fin_q, ram_rd_data};
`else
    assign fifo_push      = inflight_q;
    assign fifo_push_data = {inflight_fin_q, inflight_fin_q, ram_rd_data};
`endif

    always_comb begin
        state_d        = state_q;
        addr_d         = addr_q;
        rem_d          = rem_q;
        busy_d         = busy_q;
        done_d         = 1'b0;
        inflight_d     = issue;
        inflight_fin_d = issue && (rem_q == LEN_WIDTH'(1));
`ifdef TX_CTRL_RD_CHECKSUM_EN
        sum_d       = sum_q;
        csum_sent_d = csum_sent_q;
        if (fifo_pop && (state_q != ST_CSUM)) begin
            sum_d = sum_q + m_data;
        end
`endif
        // busy covers the done cycle, then drops.
        if (done_q) begin
            busy_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (start && !busy_q && (frame_len != '0)) begin
                    state_d = ST_RUN;
                    addr_d  = start_addr;
                    rem_d   = (frame_len > MAX_LEN) ? MAX_LEN : frame_len;
                    busy_d  = 1'b1;
`ifdef TX_CTRL_RD_CHECKSUM_EN
                    sum_d       = '0;
                    csum_sent_d = 1'b0;
`endif
                end
            end
            ST_RUN: begin
                if (issue) begin
                    addr_d = addr_q + 1'b1;
                    rem_d  = rem_q - 1'b1;
                    if (rem_q == LEN_WIDTH'(1)) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                // The final data word is the last thing queued, so its
                // acceptance means the FIFO and read pipe are empty.
                if (fifo_pop && head_fin) begin
`ifdef TX_CTRL_RD_CHECKSUM_EN
                    state_d = ST_CSUM;
`else
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
`endif
                end
            end
`ifdef TX_CTRL_RD_CHECKSUM_EN
            ST_CSUM: begin
                if (csum_push) begin
                    csum_sent_d = 1'b1;
                end
                if (fifo_pop && m_last) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge rd_clk or negedge rd_rst_n) begin
        if (!rd_rst_n) begin
            state_q        <= ST_IDLE;
            addr_q         <= '0;
            rem_q          <= '0;
            inflight_q     <= 1'b0;
            inflight_fin_q <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
`ifdef TX_CTRL_RD_CHECKSUM_EN
            sum_q          <= '0;
            csum_sent_q    <= 1'b0;
`endif
        end else begin
            state_q        <= state_d;
            addr_q         <= addr_d;
            rem_q          <= rem_d;
            inflight_q     <= inflight_d;
            inflight_fin_q <= inflight_fin_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
`ifdef TX_CTRL_RD_CHECKSUM_EN
            sum_q          <= sum_d;
            csum_sent_q    <= csum_sent_d;
`endif
        end
    end

    tx_ctrl_skid_fifo #(
        .WIDTH(FW)
    ) u_fifo (
        .clk       (rd_clk),
        .rst_n     (rd_rst_n),
        .push      (fifo_push),
        .push_data (fifo_push_data),
        .pop       (fifo_pop),
        .head_data (fifo_head),
        .head_valid(fifo_valid),
        .count     (fifo_count)
    );

    assign busy        = busy_q;
    assign done        = done_q;
    assign ram_rd_addr = addr_q;
    assign m_data      = fifo_head[DATA_WIDTH-1:0];
    assign m_valid     = fifo_valid;
    assign m_last      = fifo_valid && fifo_head[DATA_WIDTH+1];

endmodule

// File: tb/tb_tx_ctrl_rd.sv
// -----------------------------------------------------------------------------
// tb_tx_ctrl_rd
// Self-checking bench for tx_ctrl_rd with a behavioural RAM and a frame-level
// reference model (expected beat list built from the RAM contents).
// Honours TX_CTRL_RD_CHECKSUM_EN the same way as the design.
// -----------------------------------------------------------------------------
module tb_tx_ctrl_rd;

    localparam int AW = 7;
    localparam int DW = 16;
    localparam int LW = 8;
`ifdef TX_CTRL_RD_CHECKSUM_EN
    localparam int CS = 1;
`else
    localparam int CS = 0;
`endif

    logic          rd_clk = 1'b0;
    logic          rd_rst_n = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] start_addr = '0;
    logic [LW-1:0] frame_len = '0;
    logic          busy;
    logic          done;
    logic [AW-1:0] ram_rd_addr;
    logic [DW-1:0] ram_rd_data;
    logic [DW-1:0] m_data;
    logic          m_valid;
    logic          m_ready = 1'b0;
    logic          m_last;

    tx_ctrl_rd dut (
        .rd_clk     (rd_clk),
        .rd_rst_n   (rd_rst_n),
        .start      (start),
        .start_addr (start_addr),
        .frame_len  (frame_len),
        .busy       (busy),
        .done       (done),
        .ram_rd_addr(ram_rd_addr),
        .ram_rd_data(ram_rd_data),
        .m_data     (m_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_last     (m_last)
    );

    always #5 rd_clk = ~rd_clk;

    // Behavioural RAM read port: address registered, output unregistered.
    logic [DW-1:0] mem [128];
    logic [AW-1:0] ram_addr_q;
    always @(posedge rd_clk) ram_addr_q <= ram_rd_addr;
    assign ram_rd_data = mem[ram_addr_q];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int rmode = 0;
    int start_cyc, first_valid_cyc, last_acc_cyc, done_cyc, done_cnt, busy_cnt;
    logic busy_at_done;
    logic [DW:0] beat_q[$];
    logic [DW:0] exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    initial forever begin
        @(posedge rd_clk);
        cyc++;
    end

    // Ready driver: 0 = always ready, 1 = one high then two low, 2 = random.
    initial forever begin
        @(posedge rd_clk);
        #1;
        case (rmode)
            0:       m_ready = 1'b1;
            1:       m_ready = (cyc % 3 == 0);
            default: m_ready = 1'($urandom_range(0, 1));
        endcase
    end

    // Stream monitor, sampled mid-cycle.
    initial begin
        logic          prev_stall;
        logic [DW-1:0] prev_data;
        logic          prev_last;
        prev_stall = 1'b0;
        prev_data  = '0;
        prev_last  = 1'b0;
        forever begin
            @(negedge rd_clk);
            if (!rd_rst_n) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    chk("stall_valid", 32'(m_valid), 32'd1);
                    chk("stall_data", 32'(m_data), 32'(prev_data));
                    chk("stall_last", 32'(m_last), 32'(prev_last));
                end
                if (m_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
                if (m_valid && m_ready) begin
                    beat_q.push_back({m_last, m_data});
                    if (m_last) last_acc_cyc = cyc;
                end
                if (done) begin
                    done_cnt++;
                    done_cyc = cyc;
                    busy_at_done = busy;
                end
                if (busy) busy_cnt++;
                prev_stall = m_valid && !m_ready;
                prev_data  = m_data;
                prev_last  = m_last;
            end
        end
    end

    // Reference model: the frame as a list of {last, data} beats.
    task automatic build_exp(input int addr, input int len);
        int            n;
        logic [DW-1:0] sum;
        logic [DW-1:0] d;
        logic          l;
        exp_q.delete();
        n   = (len > 128) ? 128 : len;
        sum = '0;
        for (int i = 0; i < n; i++) begin
            d   = mem[(addr + i) % 128];
            sum = sum + d;
            l   = (CS == 0) && (i == n - 1);
            exp_q.push_back({l, d});
        end
        if (CS != 0 && n > 0) exp_q.push_back({1'b1, ~sum});
    endtask

    task automatic clear_mon();
        beat_q.delete();
        first_valid_cyc = -1;
        last_acc_cyc    = -1;
        done_cyc        = -1;
        done_cnt        = 0;
        busy_cnt        = 0;
        busy_at_done    = 1'b0;
    endtask

    task automatic run_frame(input int addr, input int len, input int mode, input bit inject);
        bit finished;
        int n;
        rmode = mode;
        clear_mon();
        build_exp(addr, len);
        @(posedge rd_clk);
        #1;
        start      = 1'b1;
        start_addr = addr[AW-1:0];
        frame_len  = len[LW-1:0];
        start_cyc  = cyc;
        @(posedge rd_clk);
        #1;
        start      = 1'b0;
        start_addr = AW'($urandom);
        frame_len  = LW'($urandom);
        chk("busy_rise", 32'(busy), 32'd1);
        finished = 1'b0;
        for (int c = 0; c < 3000 && !finished; c++) begin
            @(negedge rd_clk);
            #1;
            if (inject && c == 3) begin
                start      = 1'b1;
                start_addr = 7'd50;
                frame_len  = 8'd3;
            end else begin
                start = 1'b0;
            end
            if (done_cnt != 0) finished = 1'b1;
        end
        start = 1'b0;
        chk("frame_timeout", 32'(finished), 32'd1);
        repeat (3) @(negedge rd_clk);
        #1;
        chk("done_count", 32'(done_cnt), 32'd1);
        chk("busy_at_done", 32'(busy_at_done), 32'd1);
        chk("busy_fall", 32'(busy), 32'd0);
        chk("first_latency", 32'(first_valid_cyc - start_cyc), 32'd3);
        chk("done_delay", 32'(done_cyc - last_acc_cyc), 32'd1);
        chk("beat_count", 32'(beat_q.size()), 32'(exp_q.size()));
        n = (beat_q.size() < exp_q.size()) ? beat_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            chk("beat", 32'(beat_q[i]), 32'(exp_q[i]));
        end
        $display("frame addr=%0d len=%0d ready_mode=%0d beats=%0d done=%0d",
                 addr, len, mode, beat_q.size(), done_cnt);
    endtask

    typedef struct {
        int            addr;
        int            len;
        int            mode;
        int            exp_n;
        logic [DW-1:0] exp_first;
        logic [DW-1:0] exp_last;
    } vec_t;

    initial begin
        vec_t vecs[5];
        int   act_n;
        bit   reached;

        vecs[0] = '{addr: 0,   len: 4,   mode: 0, exp_n: 4,   exp_first: 16'h1000, exp_last: 16'h1003};
        vecs[1] = '{addr: 126, len: 4,   mode: 0, exp_n: 4,   exp_first: 16'h107E, exp_last: 16'h1001};
        vecs[2] = '{addr: 0,   len: 128, mode: 1, exp_n: 128, exp_first: 16'h1000, exp_last: 16'h107F};
        vecs[3] = '{addr: 5,   len: 200, mode: 2, exp_n: 128, exp_first: 16'h1005, exp_last: 16'h1004};
        vecs[4] = '{addr: 127, len: 1,   mode: 1, exp_n: 1,   exp_first: 16'h107F, exp_last: 16'h107F};

        for (int i = 0; i < 128; i++) mem[i] = 16'h1000 + 16'(i);
        clear_mon();

        // Reset state
        repeat (3) @(negedge rd_clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_valid", 32'(m_valid), 32'd0);
        #1 rd_rst_n = 1'b1;
        repeat (2) @(negedge rd_clk);
        #1;
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_done", 32'(done), 32'd0);
        chk("idle_valid", 32'(m_valid), 32'd0);
        chk("idle_last", 32'(m_last), 32'd0);
        chk("idle_data", 32'(m_data), 32'd0);
        chk("idle_addr", 32'(ram_rd_addr), 32'd0);

        // Table-driven frames
        for (int v = 0; v < 5; v++) begin
            run_frame(vecs[v].addr, vecs[v].len, vecs[v].mode, 1'b0);
            act_n = beat_q.size() - CS;
            chk("vec_words", 32'(act_n), 32'(vecs[v].exp_n));
            if (act_n > 0) begin
                chk("vec_first", 32'(beat_q[0][DW-1:0]), 32'(vecs[v].exp_first));
                chk("vec_last_word", 32'(beat_q[act_n-1][DW-1:0]), 32'(vecs[v].exp_last));
            end
        end

        // Zero-length start is ignored
        rmode = 0;
        clear_mon();
        @(posedge rd_clk);
        #1;
        start = 1'b1; start_addr = 7'd3; frame_len = 8'd0;
        @(posedge rd_clk);
        #1;
        start = 1'b0;
        repeat (8) @(negedge rd_clk);
        #1;
        chk("zero_busy_cycles", 32'(busy_cnt), 32'd0);
        chk("zero_done", 32'(done_cnt), 32'd0);
        chk("zero_beats", 32'(beat_q.size()), 32'd0);
        $display("frame addr=3 len=0 ignored beats=%0d done=%0d", beat_q.size(), done_cnt);

        // Start while busy is ignored; running frame unaffected
        run_frame(10, 6, 0, 1'b1);
        repeat (6) @(negedge rd_clk);
        chk("inject_no_extra_beats", 32'(beat_q.size()), 32'(exp_q.size()));
        chk("inject_no_extra_done", 32'(done_cnt), 32'd1);

        // Reset mid-frame after two beats
        rmode = 0;
        clear_mon();
        @(posedge rd_clk);
        #1;
        start = 1'b1; start_addr = 7'd20; frame_len = 8'd8;
        @(posedge rd_clk);
        #1;
        start = 1'b0;
        reached = 1'b0;
        for (int c = 0; c < 50 && !reached; c++) begin
            @(negedge rd_clk);
            if (beat_q.size() >= 2) reached = 1'b1;
        end
        chk("rst_mid_reached", 32'(reached), 32'd1);
        #1 rd_rst_n = 1'b0;
        #1;
        chk("rst_mid_busy", 32'(busy), 32'd0);
        chk("rst_mid_done", 32'(done), 32'd0);
        chk("rst_mid_valid", 32'(m_valid), 32'd0);
        chk("rst_mid_last", 32'(m_last), 32'd0);
        chk("rst_mid_data", 32'(m_data), 32'd0);
        chk("rst_mid_addr", 32'(ram_rd_addr), 32'd0);
        repeat (3) @(negedge rd_clk);
        #1 rd_rst_n = 1'b1;
        repeat (5) @(negedge rd_clk);
        chk("rst_mid_no_done", 32'(done_cnt), 32'd0);
        chk("rst_mid_beats", 32'(beat_q.size()), 32'd2);
        $display("frame addr=20 len=8 reset after beats=%0d done=%0d", beat_q.size(), done_cnt);
        run_frame(40, 2, 0, 1'b0);

`ifdef TX_CTRL_RD_CHECKSUM_EN
        mem[60] = 16'h0001;
        mem[61] = 16'h0002;
        mem[62] = 16'hFFFF;
        run_frame(60, 3, 0, 1'b0);
        if (beat_q.size() == 4) begin
            chk("csum_word", 32'(beat_q[3]), 32'h1FFFD);
            chk("csum_data_last", 32'(beat_q[2][DW]), 32'd0);
        end else begin
            chk("csum_beats", 32'(beat_q.size()), 32'd4);
        end
`endif

        // Randomised frames against the model
        for (int r = 0; r < 12; r++) begin
            for (int i = 0; i < 128; i++) mem[i] = DW'($urandom);
            run_frame($urandom_range(0, 127), $urandom_range(1, 140), $urandom_range(0, 2), 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
